mem_stage: RTL
==============

# mem_stage

Memory stage of the NOVA core pipeline. Sits between the EX stage and the WB register. It latches EX results and performs loads and stores over a req/ack data-memory bus, stalling upstream while an access is outstanding. It presents the destination register and its value to the forwarding unit, then hands completed results to writeback.

## Interface
- XLEN, 32 (from rapid_pkg): datapath width; only 32 supported.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_ex_valid  in  1  EX holds a valid instruction.
- i_ex_rd  in  5  destination register.
- i_ex_reg_write  in  1  instruction writes rd.
- i_ex_mem_read / i_ex_mem_write  in  1 each  load / store (never both).
- i_ex_funct3  in  3  access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- i_ex_alu_result  in  XLEN  ALU result or effective address.
- i_ex_store_data  in  XLEN  forwarded rs2 value.
- o_stall  out  1  MEM cannot accept; EX must hold.
- o_mem_rd  out  5  rd of the MEM-resident instruction, to forwarding.
- o_mem_rd_data  out  XLEN  forwardable value.
- o_mem_fwd_valid  out  1  o_mem_rd_data is usable (valid, reg_write, rd≠0, not a pending load).
- o_dmem_req, o_dmem_we  out  1 each  bus request, write enable.
- o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- o_dmem_wdata  out  XLEN  lane-replicated store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_ack  in  1  access complete this cycle.
- i_dmem_rdata  in  XLEN  read word, valid with ack.
- o_wb_valid, o_wb_reg_write  out  1 each  registered result to WB.
- o_wb_rd  out  5; o_wb_data  out  XLEN.

## Operation
- MEM register (valid, rd, reg_write, mem_read, mem_write, funct3, alu_result, store_data) loads from EX on each edge where o_stall=0. i_ex_valid=0 loads a bubble.
- FSM states are IDLE and WAIT.
  - IDLE→WAIT: accepting a valid mem op.
  - WAIT→IDLE: i_dmem_ack=1 with no new mem op accepted.
  - WAIT→WAIT: ack=1 with a new mem op accepted, or ack=0.
- o_dmem_req=1 exactly in WAIT. addr/we/wdata/be are driven from the MEM register and held stable until ack.
- o_stall = (state==WAIT) & ~i_dmem_ack.
- Store lanes:
  - SB: be=0001<<addr[1:0]; wdata={4{byte}}.
  - SH: be=0011<<{addr[1],1'b0}; wdata={2{half}}.
  - SW: be=1111.
  - Loads drive be=1111, we=0.
- Load extract: select the byte or half by addr bits, then sign- or zero-extend per funct3.
- WB register updates every edge where o_stall=0:
  - o_wb_valid = MEM valid.
  - o_wb_data = formatted load data for loads, else alu_result.
  - o_wb_reg_write = reg_write & ~mem_write.
- o_mem_rd_data = alu_result. o_mem_fwd_valid is 0 for loads.
- i_dmem_ack while IDLE is ignored.

## Timing
- Reset values: every output 0, state IDLE, MEM register valid=0.
- ALU op: EX at cycle N. Forwarding outputs are visible at N+1. o_wb_* is valid at N+2.
- Load/store with ack in the first WAIT cycle: zero stall cycles, o_wb_* at N+2.
- Each cycle ack is delayed adds one stall cycle and one cycle of WB latency.
- Reset asserted in WAIT: req drops after the reset edge, the transaction is abandoned, and a later ack is ignored.
- Back-to-back mem ops: ack and acceptance of the next op on the same edge keeps req high continuously, with the new address.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) issues no bus request and stays in IDLE.
  - Adds o_misaligned (1b) and o_fault_addr (XLEN), registered alongside o_wb_*.
  - o_misaligned pulses with o_wb_valid; o_wb_reg_write is forced 0.
- Undefined: no extra ports. Half accesses ignore addr[0]; word accesses ignore addr[1:0].

## Structure
- rapid_pkg gains mem_size_e (funct3 encodings above) and mem_state_e {IDLE, WAIT}.
- One combinational sub-module, load_store_align: (funct3, addr[1:0], store_data, rdata) → (be, wdata, load_data).

## Test plan
- ALU op rd=5, result 0xDEADBEEF → o_mem_rd=5, fwd_valid=1 at N+1; o_wb_data=0xDEADBEEF at N+2, zero stalls.
- SB addr 0x1003 data 0x000000A5, ack after 3 WAIT cycles → be=1000, wdata=0xA5A5A5A5, addr=0x1000, o_stall high for exactly 2 cycles, o_wb_reg_write=0.
- LB addr 0x2001, rdata 0x0000_80_00 → o_wb_data=0xFFFFFF80. LBU → 0x00000080. LH addr 0x2002, rdata 0x8001_0000 → 0xFFFF8001.
- Load then store back-to-back, ack each first cycle → req continuously high two cycles, addresses change on the edge, no stall.
- Reset during WAIT, then stray ack → req=0, all outputs 0 after the reset edge, ack ignored, no WB write.
- MEM_MISALIGN_TRAP_EN, LW addr 0x3002 → no req, o_misaligned=1, o_fault_addr=0x3002, o_wb_reg_write=0.

Source files
------------

// File: rtl/rapid_pkg.sv
// Types shared by the NOVA pipeline stages: memory access sizes, MEM FSM states,
// pipeline register layouts and the misalignment rule.
package rapid_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
  } mem_reg_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_reg_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (mem_size_e'(funct3))
      MEM_H, MEM_HU: return addr_lo[0];
      MEM_W:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering between the core and a 32-bit word-wide data bus.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are used.
module load_store_align
  import rapid_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (mem_size_e'(funct3))
      MEM_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_H:   load_data = {{16{half_sel[15]}}, half_sel};
      MEM_BU:  load_data = {24'h0, byte_sel};
      MEM_HU:  load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// NOVA MEM stage: latches EX, runs loads/stores over req/ack, feeds forwarding and WB (MEM_MISALIGN_TRAP_EN adds misalign trap).
// Latency: forwarding at N+1, WB at N+2 plus one cycle per cycle of delayed ack.
// Backpressure: o_stall holds EX while a bus access waits for ack.
module mem_stage
  import rapid_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex_valid,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_ex_reg_write,
  input  logic            i_ex_mem_read,
  input  logic            i_ex_mem_write,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_alu_result,
  input  logic [XLEN-1:0] i_ex_store_data,
  output logic            o_stall,
  output logic [4:0]      o_mem_rd,
  output logic [XLEN-1:0] o_mem_rd_data,
  output logic            o_mem_fwd_valid,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_wb_valid,
  output logic            o_wb_reg_write,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_fault_addr
`endif
);

  mem_reg_t   mem_q, mem_d;
  wb_reg_t    wb_q, wb_d;
  mem_state_e state_q, state_d;

  logic            stall;
  logic            ex_mem_op;
  logic            ex_misaligned;
  logic            mem_misaligned;
  logic [3:0]      lsa_be;
  logic [XLEN-1:0] lsa_wdata;
  logic [XLEN-1:0] lsa_load_data;

  load_store_align u_align (
    .funct3     (mem_q.funct3),
    .addr_lo    (mem_q.alu_result[1:0]),
    .store_data (mem_q.store_data),
    .rdata      (i_dmem_rdata),
    .be         (lsa_be),
    .wdata      (lsa_wdata),
    .load_data  (lsa_load_data)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;

  assign ex_misaligned  = is_misaligned(i_ex_funct3, i_ex_alu_result[1:0]);
  assign mem_misaligned = mem_q.valid & (mem_q.mem_read | mem_q.mem_write) &
                          is_misaligned(mem_q.funct3, mem_q.alu_result[1:0]);
  assign o_misaligned   = misaligned_q;
  assign o_fault_addr   = fault_addr_q;
`else
  assign ex_misaligned  = 1'b0;
  assign mem_misaligned = 1'b0;
`endif

  assign stall     = (state_q == WAIT) & ~i_dmem_ack;
  assign ex_mem_op = i_ex_valid & (i_ex_mem_read | i_ex_mem_write) & ~ex_misaligned;

  always_comb begin
    mem_d   = mem_q;
    wb_d    = wb_q;
    state_d = state_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
    fault_addr_d = fault_addr_q;
`endif
    if (!stall) begin
      // A bubble clears every field so nothing downstream can act on it.
      mem_d = '0;
      if (i_ex_valid) begin
        mem_d.valid      = 1'b1;
        mem_d.rd         = i_ex_rd;
        mem_d.reg_write  = i_ex_reg_write;
        mem_d.mem_read   = i_ex_mem_read;
        mem_d.mem_write  = i_ex_mem_write;
        mem_d.funct3     = i_ex_funct3;
        mem_d.alu_result = i_ex_alu_result;
        mem_d.store_data = i_ex_store_data;
      end
      wb_d.valid     = mem_q.valid;
      wb_d.rd        = mem_q.rd;
      wb_d.reg_write = mem_q.reg_write & ~mem_q.mem_write & ~mem_misaligned;
      wb_d.data      = (mem_q.mem_read & ~mem_misaligned) ? lsa_load_data : mem_q.alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_d = mem_misaligned;
      fault_addr_d = mem_misaligned ? mem_q.alu_result : '0;
`endif
      state_d = ex_mem_op ? WAIT : IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mem_q   <= '0;
      wb_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
      fault_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
      fault_addr_q <= fault_addr_d;
`endif
    end
  end

  assign o_stall         = stall;
  assign o_mem_rd        = mem_q.rd;
  assign o_mem_rd_data   = mem_q.alu_result;
  assign o_mem_fwd_valid = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0) & ~mem_q.mem_read;

  // Bus fields are qualified by req so an idle bus reads as all zeros.
  assign o_dmem_req   = (state_q == WAIT);
  assign o_dmem_we    = o_dmem_req & mem_q.mem_write;
  assign o_dmem_addr  = o_dmem_req ? {mem_q.alu_result[XLEN-1:2], 2'b00} : '0;
  assign o_dmem_wdata = (o_dmem_req & mem_q.mem_write) ? lsa_wdata : '0;
  assign o_dmem_be    = o_dmem_req ? (mem_q.mem_write ? lsa_be : 4'b1111) : 4'b0000;

  assign o_wb_valid     = wb_q.valid;
  assign o_wb_reg_write = wb_q.reg_write;
  assign o_wb_rd        = wb_q.rd;
  assign o_wb_data      = wb_q.data;

endmodule
